// File: rtl/note_distributor_pkg.sv
// rtl/note_distributor_pkg.sv - shared widths, constants and state encoding for note_distributor
package note_distributor_pkg;

    localparam int unsigned NOTE_W = 6;
    localparam int unsigned DUR_W  = 6;

    localparam logic [NOTE_W-1:0] REST_NOTE = 6'd0;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_WAIT  = 1'b1
    } dist_state_t;

endpackage

// File: rtl/note_distributor_free_player_select.sv
// rtl/note_distributor_free_player_select.sv - lowest-set-bit priority encoder over free players
module free_player_select #(
    parameter int unsigned NUM_PLAYERS = 3
) (
    input  logic [NUM_PLAYERS-1:0] free,
    output logic [NUM_PLAYERS-1:0] grant,
    output logic                   any_free
);

    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (free[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any_free = |free;

endmodule

// File: rtl/note_distributor.sv
// rtl/note_distributor.sv - dispatches song notes to idle note players and paces waits on beats
module note_distributor
    import note_distributor_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   play_enable,
    input  logic                   beat,
    input  logic                   note_valid,
    output logic                   note_ready,
    input  logic [NOTE_W-1:0]      entry_note,
    input  logic [DUR_W-1:0]       entry_duration,
    input  logic                   entry_is_wait,
    input  logic [NUM_PLAYERS-1:0] playing,
    output logic [NUM_PLAYERS-1:0] load_new_note,
    output logic [NOTE_W-1:0]      note_to_load,
    output logic [DUR_W-1:0]       duration_to_load,
    output logic                   idle
);

    dist_state_t            state, state_next;
    logic [DUR_W-1:0]       wait_cnt;
    logic [NUM_PLAYERS-1:0] free;
    logic [NUM_PLAYERS-1:0] grant;
    logic                   any_free;
    logic                   xfer;
    logic                   is_rest;
    logic                   is_note;

    // A player just loaded has not raised playing yet, so mask it out for that cycle.
    assign free = ~playing & ~load_new_note;

    free_player_select #(
        .NUM_PLAYERS(NUM_PLAYERS)
    ) u_select (
        .free     (free),
        .grant    (grant),
        .any_free (any_free)
    );

    assign is_rest = (entry_note == REST_NOTE);
    assign is_note = !entry_is_wait && !is_rest;
    assign xfer    = note_valid && note_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (xfer && entry_is_wait && (entry_duration != '0)) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (beat && play_enable && (wait_cnt == DUR_W'(1))) begin
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_FETCH;
        endcase
    end

    // Holding note_ready low during reset keeps a pending entry from being acknowledged.
    always_comb begin
        note_ready = 1'b0;
        idle       = 1'b0;
        if (state == ST_FETCH) begin
            note_ready = reset && play_enable && (entry_is_wait || is_rest || any_free);
            idle       = (playing == '0) && (load_new_note == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == ST_FETCH) begin
            if (xfer && entry_is_wait && (entry_duration != '0)) begin
                wait_cnt <= entry_duration;
            end
        end else if (beat && play_enable) begin
            wait_cnt <= wait_cnt - DUR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            load_new_note    <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
        end else if (xfer && is_note) begin
            load_new_note    <= grant;
            note_to_load     <= entry_note;
            duration_to_load <= entry_duration;
        end else begin
            load_new_note    <= '0;
        end
    end

endmodule

// File: doc/note_distributor.md
Name: note_distributor

Overview:
- Sits directly upstream of the NUM_PLAYERS note_player instances and consumes the song_reader note stream.
- Each song entry is either a note or a wait.
- Notes are dispatched to the lowest-index idle note_player, so notes not separated by a wait sound together as chords.
- A wait entry holds off further dispatch for its duration in beats, which is how song time advances.

Parameters:
- NUM_PLAYERS, 3: number of downstream note_player instances; legal range 1..8.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low; a low level sampled on a clk rising edge resets the block.
- play_enable  in  1  high = run; low = freeze (no accepts, no loads, wait counter held).
- beat  in  1  one-cycle 1/48 s tick.
- note_valid  in  1  song_reader presents an entry.
- note_ready  out  1  combinational; an entry transfers on a cycle with note_valid && note_ready.
- entry_note  in  6  note code; 0 = rest.
- entry_duration  in  6  duration in beats.
- entry_is_wait  in  1  1 = wait entry (entry_note ignored).
- playing  in  NUM_PLAYERS  per-player playing flags from the note_players.
- load_new_note  out  NUM_PLAYERS  one-hot load pulse, registered.
- note_to_load  out  6  shared note bus, registered.
- duration_to_load  out  6  shared duration bus, registered.
- idle  out  1  high in FETCH with playing == 0 and no load in flight.

Behaviour:
- Reset (reset low at a clk edge):
  - state = FETCH, wait_cnt = 0.
  - load_new_note = 0, note_to_load = 0, duration_to_load = 0.
  - Reset mid-WAIT or mid-dispatch aborts; a pending entry is not acknowledged.
- Free mask:
  - free = ~playing & ~load_new_note.
  - The second term masks the one-cycle gap before a loaded player raises playing.
- FETCH: note_ready = play_enable && (entry_is_wait || entry_note == 0 || free != 0). On transfer:
  - Wait, duration 0: stay in FETCH; zero time consumed.
  - Wait, duration D > 0: wait_cnt <= D, go to WAIT.
  - Rest note (entry_note == 0): entry consumed, no load.
  - Normal note: next cycle load_new_note = one-hot of the lowest set bit of free; note_to_load = entry_note; duration_to_load = entry_duration. The pulse lasts exactly 1 cycle. Stay in FETCH.
  - Throughput is at most one note per cycle.
  - When a note arrives and free == 0, note_ready stays low and the entry stalls until a player frees. Notes are never dropped or stolen.
- WAIT:
  - note_ready = 0.
  - On beat && play_enable: wait_cnt decrements; a beat while wait_cnt == 1 returns to FETCH on the same edge.
  - With play_enable low, the count is held.
- When load_new_note is zero, the buses hold their last value.
- Outputs are unaffected when a beat and a transfer occur in the same cycle, because beats only matter in WAIT.

Decomposition:
- Shared package:
  - NOTE_W = 6, DUR_W = 6, REST_NOTE = 6'd0.
  - State encoding FETCH / WAIT.
- Sub-module free_player_select: a combinational lowest-set-bit priority encoder, NUM_PLAYERS wide. Outputs are a one-hot grant and an any-free flag.

Test Plan:
- Reset: drive reset low for 2 cycles with note_valid = 1 -> note_ready = 0, load_new_note = 0, idle = 1 (with playing = 0).
- Chord: entries {note 20, dur 12}, {note 24, dur 12}, {note 27, dur 12} back to back, playing = 000 -> load_new_note = 001, then 010, then 100 on consecutive cycles. Buses carry 20/24/27 and duration 12 on the matching cycles.
- Wait: entry {wait, dur 3} then note 30 -> the note is not accepted until the 3rd beat after the wait transfer; wait_cnt reaches 0 exactly then.
- Saturation: playing = 111, note 15 presented -> note_ready = 0 for 50 cycles. Then drop playing[1] -> accept that cycle, and load_new_note = 010 next cycle.
- Boundaries: rest note 0 -> accepted with no load. Wait dur 0 -> accepted with no stall. play_enable low during WAIT with beats -> wait_cnt frozen.
- Reset mid-WAIT: reset low with wait_cnt = 5 -> next cycle FETCH, wait_cnt = 0, pending note presented is not acknowledged during reset.
